color_sensor_poller: RTL and testbench

//  Parametrised successor to the fixed 4-channel RGBC reader. Drives a byte-level I2C master to

---
 rtl/color_sensor_poller.sv | 277 +++++++++++++++++++++++++++
 tb/tb_color_sensor_poller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_sensor_poller.sv
// color_sensor_poller
// Drives a byte-level I2C master to initialise an RGBC-class colour sensor.
// It polls STATUS.AVALID, burst-reads NUM_CH channels into a shadow buffer and
// publishes them atomically. Supports single-shot and continuous modes, NACK
// retry, a poll timeout and a sticky error flag.

module color_sensor_poller #(
    parameter int         NUM_CH    = 4,
    parameter int         CH_WIDTH  = 16,
    parameter logic [7:0] DATA_BASE = 8'h14,
    parameter logic [7:0] CMD_BIT   = 8'h80,
    parameter logic [7:0] ATIME_VAL = 8'hFF,
    parameter logic [7:0] GAIN_VAL  = 8'h02,
    parameter int         PON_WAIT  = 28800,
    parameter int         POLL_GAP  = 1200,
    parameter int         POLL_MAX  = 64,
    parameter int         RETRY_MAX = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       continuous,
    input  logic                       trigger,
    output logic                       i2c_cmd_valid,
    input  logic                       i2c_cmd_ready,
    output logic                       i2c_rw,
    output logic [7:0]                 i2c_reg,
    output logic [7:0]                 i2c_wdata,
    input  logic                       i2c_done,
    input  logic                       i2c_nack,
    input  logic [7:0]                 i2c_rdata,
    output logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    output logic                       data_valid,
    output logic                       err,
    output logic                       busy
);

    localparam int BYTES  = CH_WIDTH / 8;
    localparam int NBYTES = NUM_CH * BYTES;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [3:0] {
        S_INIT_PON,
        S_WAIT_PON,
        S_INIT_ATIME,
        S_INIT_GAIN,
        S_INIT_AEN,
        S_IDLE,
        S_POLL,
        S_POLL_WAIT,
        S_READ,
        S_PUBLISH,
        S_ERROR
    } state_t;

    state_t state_reg, state_next;

    logic                       cmd_valid_reg;
    logic                       pend_reg;
    logic                       rw_reg;
    logic [7:0]                 reg_addr_reg;
    logic [7:0]                 wdata_reg;
    logic [31:0]                wait_cnt_reg;
    logic [7:0]                 retry_cnt_reg;
    logic [15:0]                poll_cnt_reg;
    logic [IDX_W-1:0]           byte_idx_reg;
    logic [7:0]                 shadow_reg [NBYTES];
    logic [NBYTES*8-1:0]        shadow_flat;
    logic [NUM_CH*CH_WIDTH-1:0] ch_data_reg;
    logic                       data_valid_reg;
    logic                       err_reg;
    logic                       busy_reg;

    // Transfer descriptor for the current state
    logic       x_req;
    logic       x_rw;
    logic [7:0] x_reg;
    logic [7:0] x_wdata;

    // Completion events only count for the transfer we actually have in flight
    logic ack_evt, nack_evt, give_up, state_chg;
    assign ack_evt   = pend_reg && i2c_done && !i2c_nack;
    assign nack_evt  = pend_reg && i2c_done && i2c_nack;
    assign give_up   = nack_evt && (retry_cnt_reg == 8'(RETRY_MAX));
    assign state_chg = (state_next != state_reg);

    // Byte i sits at bit i*8, which is channel i/BYTES, lane i%BYTES, low byte first
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_flat
            assign shadow_flat[gi*8 +: 8] = shadow_reg[gi];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_INIT_PON;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the transfer each state wants to issue
    always_comb begin
        state_next = state_reg;
        x_req      = 1'b0;
        x_rw       = 1'b0;
        x_reg      = 8'h00;
        x_wdata    = 8'h00;
        case (state_reg)
            S_INIT_PON: begin
                x_req   = 1'b1;
                x_reg   = 8'h00 | CMD_BIT;
                x_wdata = 8'h01;
                if (give_up)      state_next = S_ERROR;
                else if (ack_evt) state_next = S_WAIT_PON;
            end
            S_WAIT_PON: begin
                if (wait_cnt_reg == 32'(PON_WAIT - 1)) state_next = S_INIT_ATIME;
            end
            S_INIT_ATIME: begin
                x_req   = 1'b1;
                x_reg   = 8'h01 | CMD_BIT;
                x_wdata = ATIME_VAL;
                if (give_up)      state_next = S_ERROR;
                else if (ack_evt) state_next = S_INIT_GAIN;
            end
            S_INIT_GAIN: begin
                x_req   = 1'b1;
                x_reg   = 8'h0F | CMD_BIT;
                x_wdata = GAIN_VAL;
                if (give_up)      state_next = S_ERROR;
                else if (ack_evt) state_next = S_INIT_AEN;
            end
            S_INIT_AEN: begin
                x_req   = 1'b1;
                x_reg   = 8'h00 | CMD_BIT;
                x_wdata = 8'h03;
                if (give_up)      state_next = S_ERROR;
                else if (ack_evt) state_next = continuous ? S_POLL : S_IDLE;
            end
            S_IDLE: begin
                if (trigger || continuous) state_next = S_POLL;
            end
            S_POLL: begin
                x_req = 1'b1;
                x_rw  = 1'b1;
                x_reg = 8'h13 | CMD_BIT;
                if (give_up) begin
                    state_next = S_ERROR;
                end else if (ack_evt) begin
                    if (i2c_rdata[0])                               state_next = S_READ;
                    else if (poll_cnt_reg == 16'(POLL_MAX - 1))     state_next = S_ERROR;
                    else                                            state_next = S_POLL_WAIT;
                end
            end
            S_POLL_WAIT: begin
                if (wait_cnt_reg == 32'(POLL_GAP - 1)) state_next = S_POLL;
            end
            S_READ: begin
                x_req = 1'b1;
                x_rw  = 1'b1;
                x_reg = (DATA_BASE + 8'(byte_idx_reg)) | CMD_BIT;
                if (give_up) begin
                    state_next = S_ERROR;
                end else if (ack_evt && (byte_idx_reg == IDX_W'(NBYTES - 1))) begin
                    state_next = S_PUBLISH;
                end
            end
            S_PUBLISH: begin
                state_next = continuous ? S_POLL : S_IDLE;
            end
            S_ERROR: begin
                if (wait_cnt_reg == 32'(PON_WAIT - 1)) state_next = S_INIT_PON;
            end
            default: state_next = S_INIT_PON;
        endcase
    end

    // Request/accept/complete handshake: one transfer in flight, fields frozen until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_reg <= 1'b0;
            pend_reg      <= 1'b0;
            rw_reg        <= 1'b0;
            reg_addr_reg  <= 8'h00;
            wdata_reg     <= 8'h00;
        end else if (state_chg) begin
            cmd_valid_reg <= 1'b0;
            pend_reg      <= 1'b0;
        end else if (cmd_valid_reg) begin
            if (i2c_cmd_ready) begin
                cmd_valid_reg <= 1'b0;
                pend_reg      <= 1'b1;
            end
        end else if (pend_reg) begin
            // A NACK lands here too; the same transfer is re-issued next cycle
            if (i2c_done) pend_reg <= 1'b0;
        end else if (x_req) begin
            cmd_valid_reg <= 1'b1;
            rw_reg        <= x_rw;
            reg_addr_reg  <= x_reg;
            wdata_reg     <= x_wdata;
        end
    end

    // Wait timer, retry/poll counters and read byte index
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg  <= '0;
            retry_cnt_reg <= '0;
            poll_cnt_reg  <= '0;
            byte_idx_reg  <= '0;
        end else begin
            if (state_chg) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == S_WAIT_PON || state_reg == S_POLL_WAIT ||
                         state_reg == S_ERROR) begin
                wait_cnt_reg <= wait_cnt_reg + 32'd1;
            end

            if (ack_evt || give_up) retry_cnt_reg <= '0;
            else if (nack_evt)      retry_cnt_reg <= retry_cnt_reg + 8'd1;

            if (state_reg == S_POLL && ack_evt) begin
                poll_cnt_reg <= i2c_rdata[0] ? 16'd0 : poll_cnt_reg + 16'd1;
            end else if (state_reg == S_ERROR) begin
                poll_cnt_reg <= '0;
            end

            if (state_reg != S_READ) byte_idx_reg <= '0;
            else if (ack_evt)        byte_idx_reg <= byte_idx_reg + IDX_W'(1);
        end
    end

    // Shadow buffer: each byte lane captures its own read
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg[gi] <= 8'h00;
                end else if (state_reg == S_READ && ack_evt &&
                             byte_idx_reg == IDX_W'(gi)) begin
                    shadow_reg[gi] <= i2c_rdata;
                end
            end
        end
    endgenerate

    // Published data, frame strobe, sticky error and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_data_reg    <= '0;
            data_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            data_valid_reg <= (state_reg == S_PUBLISH);
            busy_reg       <= (state_next != S_IDLE);
            if (state_reg == S_PUBLISH) begin
                ch_data_reg <= shadow_flat;
                err_reg     <= 1'b0;
            end else if (state_reg == S_ERROR) begin
                err_reg     <= 1'b1;
            end
        end
    end

    assign i2c_cmd_valid = cmd_valid_reg;
    assign i2c_rw        = rw_reg;
    assign i2c_reg       = reg_addr_reg;
    assign i2c_wdata     = wdata_reg;
    assign ch_data       = ch_data_reg;
    assign data_valid    = data_valid_reg;
    assign err           = err_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_color_sensor_poller.sv
// Scoreboard bench for color_sensor_poller: a 4x16-bit instance with a
// configurable slave model and a 3x8-bit instance with an always-ACK slave.
module tb_color_sensor_poller;

    logic        clk = 1'b0;
    logic        rst, continuous, trigger, trigger2;
    logic        cmd_valid, cmd_ready, rw, done, nack;
    logic [7:0]  i2c_reg, wdata, rdata;
    logic [63:0] ch_data;
    logic        data_valid, err, busy;
    logic        cmd_valid2, cmd_ready2, rw2, done2, nack2;
    logic [7:0]  i2c_reg2, wdata2, rdata2;
    logic [23:0] ch_data2;
    logic        data_valid2, err2, busy2;

    int errors = 0;
    int checks = 0;

    logic [16:0] exp_cmd[$];
    logic [63:0] exp_frame[$];
    logic [7:0]  exp_reg2[$];
    logic [23:0] exp_frame2[$];

    // slave model knobs
    int         zeros_left = 0;
    bit         always_zero = 0;
    logic [7:0] nack_reg = 8'h00;
    int         nack_left = 0;
    logic [7:0] data_ofs = 8'h10;

    always #5 clk = ~clk;

    color_sensor_poller #(.NUM_CH(4), .CH_WIDTH(16), .PON_WAIT(20), .POLL_GAP(10),
                          .POLL_MAX(4), .RETRY_MAX(3)) u1 (
        .clk(clk), .rst(rst), .continuous(continuous), .trigger(trigger),
        .i2c_cmd_valid(cmd_valid), .i2c_cmd_ready(cmd_ready), .i2c_rw(rw),
        .i2c_reg(i2c_reg), .i2c_wdata(wdata), .i2c_done(done), .i2c_nack(nack),
        .i2c_rdata(rdata), .ch_data(ch_data), .data_valid(data_valid),
        .err(err), .busy(busy));

    color_sensor_poller #(.NUM_CH(3), .CH_WIDTH(8), .PON_WAIT(20), .POLL_GAP(10),
                          .POLL_MAX(4), .RETRY_MAX(3)) u2 (
        .clk(clk), .rst(rst), .continuous(1'b0), .trigger(trigger2),
        .i2c_cmd_valid(cmd_valid2), .i2c_cmd_ready(cmd_ready2), .i2c_rw(rw2),
        .i2c_reg(i2c_reg2), .i2c_wdata(wdata2), .i2c_done(done2), .i2c_nack(nack2),
        .i2c_rdata(rdata2), .ch_data(ch_data2), .data_valid(data_valid2),
        .err(err2), .busy(busy2));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic push_w(input logic [7:0] r, input logic [7:0] d);
        exp_cmd.push_back({1'b0, r, d});
    endtask

    task automatic push_r(input logic [7:0] r);
        exp_cmd.push_back({1'b1, r, 8'h00});
    endtask

    task automatic push_init();
        push_w(8'h80, 8'h01); push_w(8'h81, 8'hFF); push_w(8'h8F, 8'h02); push_w(8'h80, 8'h03);
    endtask

    task automatic push_frame_cmds(input int nzero);
        for (int i = 0; i <= nzero; i++) push_r(8'h93);
        for (int i = 0; i < 8; i++) push_r(8'h94 + 8'(i));
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(busy == 1'b0 && exp_cmd.size() == 0 && exp_frame.size() == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL %s: timeout, busy=%0b cmds_left=%0d frames_left=%0d",
                     nm, busy, exp_cmd.size(), exp_frame.size());
        end
    endtask

    // Slave model + command monitor for u1 (records at the negedge before accept)
    int         out_cnt = 0;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    initial begin
        cmd_ready = 1'b1; done = 1'b0; nack = 1'b0; rdata = 8'h00;
        forever begin
            @(negedge clk);
            done = 1'b0; nack = 1'b0;
            if (rst) begin
                out_cnt = 0;
            end else if (out_cnt > 0) begin
                out_cnt--;
                if (out_cnt == 0) begin
                    done = 1'b1; nack = rsp_nack; rdata = rsp_data;
                end
            end else if (cmd_valid) begin
                logic [7:0] a;
                logic [16:0] got, want;
                got = {rw, i2c_reg, rw ? 8'h00 : wdata};
                if (exp_cmd.size() > 0) begin
                    want = exp_cmd.pop_front();
                    chk("cmd", 64'(got), 64'(want));
                end
                a = i2c_reg & 8'h7F;
                rsp_data = 8'h00;
                if (rw) begin
                    if (a == 8'h13) begin
                        if (always_zero) rsp_data = 8'h00;
                        else if (zeros_left > 0) begin zeros_left--; rsp_data = 8'h00; end
                        else rsp_data = 8'h01;
                    end else begin
                        rsp_data = data_ofs + (a - 8'h14);
                    end
                end
                rsp_nack = 1'b0;
                if (nack_left > 0 && i2c_reg == nack_reg) begin
                    rsp_nack = 1'b1; nack_left--;
                end
                out_cnt = 2;
            end
        end
    end

    // Frame monitor for u1
    initial begin
        forever begin
            @(negedge clk);
            if (data_valid) begin
                chk("frame_err_clear", 64'(err), 64'd0);
                if (exp_frame.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL frame: unexpected frame ch_data=%0h", ch_data);
                end else begin
                    chk("frame", ch_data, exp_frame.pop_front());
                end
            end
        end
    end

    // Slave model + read monitor + frame monitor for u2
    int         out_cnt2 = 0;
    logic [7:0] rsp2;
    initial begin
        cmd_ready2 = 1'b1; done2 = 1'b0; nack2 = 1'b0; rdata2 = 8'h00;
        forever begin
            @(negedge clk);
            done2 = 1'b0;
            if (data_valid2) begin
                if (exp_frame2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL frame2: unexpected frame ch_data=%0h", ch_data2);
                end else begin
                    chk("frame2", 64'(ch_data2), 64'(exp_frame2.pop_front()));
                end
            end
            if (rst) begin
                out_cnt2 = 0;
            end else if (out_cnt2 > 0) begin
                out_cnt2--;
                if (out_cnt2 == 0) begin done2 = 1'b1; rdata2 = rsp2; end
            end else if (cmd_valid2) begin
                if (rw2 && exp_reg2.size() > 0) chk("reg2", 64'(i2c_reg2), 64'(exp_reg2.pop_front()));
                rsp2 = ((i2c_reg2 & 8'h7F) == 8'h13) ? 8'h01 : 8'h10 + ((i2c_reg2 & 8'h7F) - 8'h14);
                out_cnt2 = 2;
            end
        end
    end

    // Directed stimulus
    initial begin
        int n;
        rst = 1'b1; continuous = 1'b0; trigger = 1'b0; trigger2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_data_valid", 64'(data_valid), 64'd0);
        chk("rst_ch_data", ch_data, 64'd0);
        push_init();
        rst = 1'b0;
        wait_idle("init");

        // 3x8-bit instance: regs 0x94..0x96, ch_data = {b2,b1,b0}
        exp_reg2.push_back(8'h93); exp_reg2.push_back(8'h94);
        exp_reg2.push_back(8'h95); exp_reg2.push_back(8'h96);
        exp_frame2.push_back(24'h121110);
        trigger2 = 1'b1; @(negedge clk); trigger2 = 1'b0;

        // basic frame
        push_frame_cmds(0);
        exp_frame.push_back(64'h1716151413121110);
        pulse_trigger();
        wait_idle("frame1");

        // second trigger during a frame is dropped
        push_frame_cmds(0);
        exp_frame.push_back(64'h1716151413121110);
        pulse_trigger();
        repeat (4) @(negedge clk);
        pulse_trigger();
        wait_idle("double_trigger");
        repeat (100) @(negedge clk);
        chk("busy_after_single", 64'(busy), 64'd0);

        // three not-ready polls then a frame
        zeros_left = 3;
        push_frame_cmds(3);
        exp_frame.push_back(64'h1716151413121110);
        pulse_trigger();
        wait_idle("poll_gap");

        // poll timeout -> err and full re-init
        always_zero = 1'b1;
        for (int i = 0; i < 4; i++) push_r(8'h93);
        push_init();
        pulse_trigger();
        wait_idle("poll_timeout");
        chk("poll_timeout_err", 64'(err), 64'd1);
        always_zero = 1'b0;

        // two NACKs on byte 2 then ACK: same reg re-issued, frame intact, err cleared
        nack_reg = 8'h96; nack_left = 2;
        push_r(8'h93); push_r(8'h94); push_r(8'h95); push_r(8'h96); push_r(8'h96);
        push_r(8'h96); push_r(8'h97); push_r(8'h98); push_r(8'h99); push_r(8'h9A); push_r(8'h9B);
        exp_frame.push_back(64'h1716151413121110);
        pulse_trigger();
        wait_idle("nack_retry");
        chk("nack_retry_err", 64'(err), 64'd0);

        // four NACKs -> err, published data untouched by the partial frame
        nack_reg = 8'h96; nack_left = 4; data_ofs = 8'h20;
        push_r(8'h93); push_r(8'h94); push_r(8'h95);
        for (int i = 0; i < 4; i++) push_r(8'h96);
        push_init();
        pulse_trigger();
        wait_idle("nack_giveup");
        chk("nack_giveup_err", 64'(err), 64'd1);
        chk("nack_giveup_ch_data", ch_data, 64'h1716151413121110);
        data_ofs = 8'h10;

        // reset while byte 3 is being requested
        push_r(8'h93); push_r(8'h94); push_r(8'h95); push_r(8'h96); push_r(8'h97);
        pulse_trigger();
        n = 0;
        while (!(cmd_valid && i2c_reg == 8'h97) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_byte3", 64'(n < 2000), 64'd1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        chk("midrst_data_valid", 64'(data_valid), 64'd0);
        chk("midrst_ch_data", ch_data, 64'd0);
        @(negedge clk);
        exp_cmd.delete();
        push_init();
        rst = 1'b0;
        wait_idle("reinit_after_rst");

        n = 0;
        while ((exp_reg2.size() != 0 || exp_frame2.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("u2_done", 64'(exp_reg2.size() + exp_frame2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
